// File: rtl/word_narrow_serializer_pkg.sv
// Shared encodings for the word narrowing serializer: byte-format codes
// and the serializer state machine encoding.
package word_narrow_serializer_pkg;

  typedef enum logic [1:0] {
    FMT_SEXT = 2'd0,
    FMT_ZEXT = 2'd1,
    FMT_LSBZ = 2'd2,
    FMT_FULL = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_FIRST  = 2'd1,
    ST_SEND_SECOND = 2'd2
  } state_e;

endpackage

// File: rtl/word_narrow_classify.sv
// Combinational classifier: picks the shortest byte encoding of a 16-bit word,
// checking sign-extension first, then zero-extension, then a zero low byte.
module word_narrow_classify
  import word_narrow_serializer_pkg::*;
(
  input  logic [15:0] in_word,
  output fmt_e        fmt
);

  always_comb begin
    // NOTE: every branch assigns fmt, and the final else covers the rest,
    // so no latch can be inferred here.
    if (in_word == {{8{in_word[7]}}, in_word[7:0]}) begin
      fmt = FMT_SEXT;
    end else if (in_word[15:8] == 8'h00) begin
      fmt = FMT_ZEXT;
    end else if (in_word[7:0] == 8'h00) begin
      fmt = FMT_LSBZ;
    end else begin
      fmt = FMT_FULL;
    end
  end

endmodule

// File: rtl/word_narrow_serializer.sv
// Accepts 16-bit words, narrows each to its shortest encoding and streams
// the resulting one or two bytes downstream with valid/ready handshakes.
module word_narrow_serializer
  import word_narrow_serializer_pkg::*;
#(
  parameter bit COMPRESS  = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [1:0]  out_fmt,
  output logic        out_last,
  output logic [7:0]  word_count
);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_word;
  fmt_e        r_fmt;
  logic [7:0]  r_count;

  fmt_e        w_class;
  fmt_e        w_fmt;
  logic        w_in_hs;
  logic        w_out_hs;
  logic [7:0]  w_byte;

  word_narrow_classify u_classify (
    .in_word (in_word),
    .fmt     (w_class)
  );

  assign w_fmt = COMPRESS ? w_class : FMT_FULL;

  assign out_valid = (r_state != ST_IDLE);
  assign out_last  = (r_state == ST_SEND_SECOND) ||
                     ((r_state == ST_SEND_FIRST) && (r_fmt != FMT_FULL));
  assign w_out_hs  = out_valid && out_ready;
  // Reset holds the state in IDLE, so ready must be masked explicitly.
  assign in_ready  = !reset && ((r_state == ST_IDLE) || (w_out_hs && out_last));
  assign w_in_hs   = in_valid && in_ready;

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      ST_SEND_FIRST: begin
        if ((r_fmt == FMT_LSBZ) || ((r_fmt == FMT_FULL) && MSB_FIRST)) begin
          w_byte = r_word[15:8];
        end else begin
          w_byte = r_word[7:0];
        end
      end
      ST_SEND_SECOND: w_byte = MSB_FIRST ? r_word[7:0] : r_word[15:8];
      default: ;
    endcase
  end

  assign out_byte   = w_byte;
  assign out_fmt    = out_valid ? r_fmt : FMT_SEXT;
  assign word_count = r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_hs) w_next = ST_SEND_FIRST;
      end
      ST_SEND_FIRST: begin
        if (w_out_hs) begin
          if (r_fmt == FMT_FULL) w_next = ST_SEND_SECOND;
          else                   w_next = w_in_hs ? ST_SEND_FIRST : ST_IDLE;
        end
      end
      ST_SEND_SECOND: begin
        if (w_out_hs) w_next = w_in_hs ? ST_SEND_FIRST : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_word  <= 16'h0000;
      r_fmt   <= FMT_SEXT;
      r_count <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_in_hs) begin
        r_word <= in_word;
        r_fmt  <= w_fmt;
      end
      if (w_out_hs && out_last) r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_word_narrow_serializer.sv
// Bench for word_narrow_serializer: three configurations driven side by side,
// a byte-queue model checked every cycle, plus hand-computed directed checks.
module tb_word_narrow_serializer;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] f;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid [3];
  logic [15:0] in_word;
  logic        out_ready;

  logic        o_in_ready [3];
  logic        o_valid    [3];
  logic [7:0]  o_byte     [3];
  logic [1:0]  o_fmt      [3];
  logic        o_last     [3];
  logic [7:0]  o_wc       [3];

  int total = 0;
  int bad   = 0;

  // Model: remaining bytes of the word in flight, per instance.
  exp_t mq  [3][2];
  int   mn  [3];
  int   mwc [3];
  bit   cfg_msb  [3] = '{1'b1, 1'b0, 1'b1};
  bit   cfg_comp [3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    word_narrow_serializer #(
      .COMPRESS  (g == 2 ? 1'b0 : 1'b1),
      .MSB_FIRST (g == 1 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[g]),
      .in_ready   (o_in_ready[g]),
      .in_word    (in_word),
      .out_valid  (o_valid[g]),
      .out_ready  (out_ready),
      .out_byte   (o_byte[g]),
      .out_fmt    (o_fmt[g]),
      .out_last   (o_last[g]),
      .word_count (o_wc[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void expand(input logic [15:0] w, input bit msb, input bit comp,
                                 output exp_t b0, output exp_t b1, output int n);
    int sv;
    sv = int'($signed(w));
    b1 = '0;
    if (comp && sv >= -128 && sv <= 127) begin
      b0 = '{w[7:0], 2'd0, 1'b1}; n = 1;
    end else if (comp && w < 16'd256) begin
      b0 = '{w[7:0], 2'd1, 1'b1}; n = 1;
    end else if (comp && w[7:0] == 8'h00) begin
      b0 = '{w[15:8], 2'd2, 1'b1}; n = 1;
    end else begin
      n  = 2;
      b0 = '{msb ? w[15:8] : w[7:0], 2'd3, 1'b0};
      b1 = '{msb ? w[7:0] : w[15:8], 2'd3, 1'b1};
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mn[i]  = 0;
        mwc[i] = 0;
      end else begin
        bit   rdy;
        exp_t b0, b1;
        int   n;
        rdy = (mn[i] == 0) || (mn[i] == 1 && out_ready);
        if (mn[i] > 0 && out_ready) begin
          if (mq[i][0].l) mwc[i] = (mwc[i] + 1) % 256;
          mq[i][0] = mq[i][1];
          mn[i]--;
        end
        if (in_valid[i] && rdy) begin
          expand(in_word, cfg_msb[i], cfg_comp[i], b0, b1, n);
          mq[i][0] = b0;
          mq[i][1] = b1;
          mn[i]    = n;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    for (int i = 0; i < 3; i++) begin
      bit exp_rdy;
      exp_rdy = !reset && ((mn[i] == 0) || (mn[i] == 1 && out_ready));
      check($sformatf("cmp%0d_in_ready", i), 32'(o_in_ready[i]), 32'(exp_rdy));
      check($sformatf("cmp%0d_valid", i), 32'(o_valid[i]), 32'(!reset && mn[i] > 0));
      check($sformatf("cmp%0d_count", i), 32'(o_wc[i]), reset ? 32'd0 : 32'(mwc[i]));
      if (!reset && mn[i] > 0) begin
        check($sformatf("cmp%0d_byte", i), 32'(o_byte[i]), 32'(mq[i][0].b));
        check($sformatf("cmp%0d_fmt", i), 32'(o_fmt[i]), 32'(mq[i][0].f));
        check($sformatf("cmp%0d_last", i), 32'(o_last[i]), 32'(mq[i][0].l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int k, input logic [7:0] b,
                            input logic [1:0] f, input logic l);
    check({name, "_valid"}, 32'(o_valid[k]), 32'd1);
    check({name, "_byte"}, 32'(o_byte[k]), 32'(b));
    check({name, "_fmt"}, 32'(o_fmt[k]), 32'(f));
    check({name, "_last"}, 32'(o_last[k]), 32'(l));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = '{1'b0, 1'b0, 1'b0};
    in_word   = 16'h0000;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(o_valid[0]), 32'd0);
    check("rst_in_ready", 32'(o_in_ready[0]), 32'd0);
    check("rst_count", 32'(o_wc[0]), 32'd0);
    check("rst_byte", 32'(o_byte[0]), 32'd0);
    check("rst_fmt", 32'(o_fmt[0]), 32'd0);
    check("rst_last", 32'(o_last[0]), 32'd0);
    reset = 1'b0;

    // Short forms back to back
    in_valid[0] = 1'b1;
    in_word     = 16'hFF80;
    tick();
    expect_out("sext", 0, 8'h80, 2'd0, 1'b1);
    check("sext_in_ready", 32'(o_in_ready[0]), 32'd1);
    in_word = 16'h0080;
    tick();
    expect_out("zext", 0, 8'h80, 2'd1, 1'b1);
    in_valid[0] = 1'b0;
    tick();
    check("short_count", 32'(o_wc[0]), 32'd2);
    check("short_idle", 32'(o_valid[0]), 32'd0);

    // LSBZ then zero word
    in_valid[0] = 1'b1;
    in_word     = 16'h1200;
    tick();
    expect_out("lsbz", 0, 8'h12, 2'd2, 1'b1);
    in_word = 16'h0000;
    tick();
    expect_out("zero", 0, 8'h00, 2'd0, 1'b1);
    in_valid[0] = 1'b0;
    tick();

    // FULL in both byte orders, then forced FULL with compression off
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    in_word     = 16'h1234;
    tick();
    expect_out("full_msb_b0", 0, 8'h12, 2'd3, 1'b0);
    expect_out("full_lsb_b0", 1, 8'h34, 2'd3, 1'b0);
    check("full_in_ready", 32'(o_in_ready[0]), 32'd0);
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    tick();
    expect_out("full_msb_b1", 0, 8'h34, 2'd3, 1'b1);
    expect_out("full_lsb_b1", 1, 8'h12, 2'd3, 1'b1);
    tick();
    in_valid[2] = 1'b1;
    in_word     = 16'h0005;
    tick();
    expect_out("nocomp_b0", 2, 8'h00, 2'd3, 1'b0);
    in_valid[2] = 1'b0;
    tick();
    expect_out("nocomp_b1", 2, 8'h05, 2'd3, 1'b1);
    tick();

    // Backpressure mid-FULL; a competing word must be ignored
    in_valid[0] = 1'b1;
    in_word     = 16'h5678;
    tick();
    out_ready = 1'b0;
    in_word   = 16'hDEAD;
    for (int c = 0; c < 5; c++) begin
      expect_out("stall", 0, 8'h56, 2'd3, 1'b0);
      check("stall_in_ready", 32'(o_in_ready[0]), 32'd0);
      tick();
    end
    out_ready   = 1'b1;
    in_valid[0] = 1'b0;
    tick();
    expect_out("release_b1", 0, 8'h78, 2'd3, 1'b1);
    tick();
    check("release_count", 32'(o_wc[0]), 32'd6);
    check("release_idle", 32'(o_valid[0]), 32'd0);

    // Reset mid-word, then 256 words to wrap the counter
    in_valid[0] = 1'b1;
    in_word     = 16'hABCD;
    tick();
    in_valid[0] = 1'b0;
    expect_out("pre_rst", 0, 8'hAB, 2'd3, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(o_valid[0]), 32'd0);
    check("midrst_count", 32'(o_wc[0]), 32'd0);
    check("midrst_in_ready", 32'(o_in_ready[0]), 32'd0);
    check("midrst_byte", 32'(o_byte[0]), 32'd0);
    tick();
    reset       = 1'b0;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_word = 16'(i);
      tick();
      if (i == 0) expect_out("post_rst_first", 0, 8'h00, 2'd0, 1'b1);
    end
    in_valid[0] = 1'b0;
    check("wrap_255", 32'(o_wc[0]), 32'd255);
    expect_out("wrap_lastword", 0, 8'hFF, 2'd1, 1'b1);
    tick();
    check("wrap_0", 32'(o_wc[0]), 32'd0);
    check("wrap_idle", 32'(o_valid[0]), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_narrow_serializer.md
WORD_NARROW_SERIALIZER -- requirements
Module: word_narrow_serializer

Interface
REQ-001 The block SHALL have parameter COMPRESS, default 1: 1 enables short forms, 0 forces FULL for every word.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: in FULL form, the high byte goes first when 1 and the low byte first when 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts in_word this cycle.
REQ-007 The block SHALL have port in_word, input, 16 bits: word to narrow and serialize.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_byte, out_fmt and out_last are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the byte.
REQ-010 The block SHALL have port out_byte, output, 8 bits: emitted byte.
REQ-011 The block SHALL have port out_fmt, output, 2 bits: encoding of the current word (SEXT=0, ZEXT=1, LSBZ=2, FULL=3).
REQ-012 The block SHALL have port out_last, output, 1 bit: final byte of the current word.
REQ-013 The block SHALL have port word_count, output, 8 bits: count of fully emitted words, wrapping.

Function
REQ-014 The block SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready (the handshakes).
REQ-015 The block SHALL classify each word on acceptance, using the first matching rule in this order:
- SEXT when in_word == {8{in_word[7]}, in_word[7:0]}
- ZEXT when in_word[15:8]==0
- LSBZ when in_word[7:0]==0
- otherwise FULL
REQ-016 The block SHALL emit one byte for SEXT and ZEXT (low byte), one byte for LSBZ (high byte), and two bytes for FULL.
REQ-017 The block SHALL use the states IDLE, SEND_FIRST and SEND_SECOND.
- IDLE -> SEND_FIRST on input handshake.
- SEND_FIRST -> SEND_SECOND on output handshake when fmt==FULL.
- Otherwise a last-byte handshake returns to IDLE, or to SEND_FIRST if a new word is accepted in the same cycle.
REQ-018 The block SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_last), combinationally, and 0 while reset is asserted.
REQ-019 The block SHALL present the first byte with out_valid=1 in the cycle after acceptance, giving 1-cycle latency.
REQ-020 The block SHALL sustain one word per cycle for short forms and one word per two cycles for FULL.
REQ-021 The block SHALL hold out_byte, out_fmt and out_last stable while out_valid && !out_ready.
REQ-022 The block SHALL set out_last=1 on the single byte of a short form and on the second byte of FULL.
REQ-023 The block SHALL increment word_count on each out_last handshake, wrapping 255->0.
REQ-024 The block SHALL ignore in_word while in_ready=0.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, out_valid=0, out_byte=0, out_fmt=0, out_last=0 and word_count=0.
REQ-026 Reset mid-word SHALL discard the partially sent word without incrementing word_count.
REQ-027 After deassertion, the block SHALL accept a word on the first rising edge at which in_valid=1.

Structure
REQ-028 A shared package SHALL hold the FMT_* 2-bit encodings and the state encoding.
REQ-029 Classification SHALL be a combinational sub-module word_narrow_classify (in 16 bits, fmt 2 bits).

Verification
REQ-030 Short forms, out_ready=1: input 0xFF80 then 0x0080 back-to-back -> bytes 0x80/fmt0 then 0x80/fmt1, out_last=1 each, one byte per cycle, word_count=2.
REQ-031 LSBZ and zero: input 0x1200 then 0x0000 -> 0x12/fmt2, then 0x00/fmt0.
REQ-032 FULL: input 0x1234 with MSB_FIRST=1 -> 0x12 (last=0) then 0x34 (last=1), fmt3; with MSB_FIRST=0 -> 0x34 then 0x12; with COMPRESS=0, input 0x0005 -> 0x00 then 0x05, fmt3.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles mid-FULL -> outputs stable, in_ready=0; release -> sequence completes intact.
REQ-034 Reset and wrap: assert reset after the first byte of 0xABCD -> out_valid=0 at once and word_count=0; afterwards, 256 words -> word_count wraps to 0.
